joy_dir_arbiter: RTL and testbench
==================================

# joy_dir_arbiter

Per-player joystick direction conditioner between the keyboard/joystick merge logic and the game core's active-low control inputs. It handles CHANNELS players and does the following per channel:
- applies optional 90° rotation for horizontal-cabinet play;
- synchronises and debounces each direction bit;
- arbitrates simultaneous directions according to a run-time mode: 8-way with opposite cancel, 4-way last-pressed, 4-way first-held, or 2-way horizontal.

It generalises the earlier single-channel, 4-way, last-pressed filter. It adds per-channel state, debounce, more modes, and re-selection of a still-held direction on release.

## Interface
Parameters:
- CHANNELS, 2, number of independent players (1..4).
- DEB_LEN, 8, consecutive ce ticks a raw level must persist before acceptance. 0 bypasses debounce.

Ports:
- clk_sys  in  1  system clock; all state on rising edge.
- I_RESETn  in  1  asynchronous, active-low reset.
- ce  in  1  debounce tick enable. Ignored when DEB_LEN=0.
- mode  in  2  00 8-way/opposite-cancel, 01 4-way last-pressed, 10 4-way first-held, 11 2-way horizontal.
- rotate  in  1  1 = remap directions for horizontal orientation.
- dir_in  in  4*CHANNELS  active-high raw directions. Channel c occupies [4c+3:4c], ordered {up,down,left,right}.
- dir_out  out  4*CHANNELS  arbitrated active-high directions, same packing.
- chg  out  CHANNELS  one-cycle pulse when the channel's dir_out changes.

## Operation
Per channel, the datapath runs in this order:

1. **Rotate** (combinational). With rotate=1: up←left_in, down←right_in, left←down_in, right←up_in. With rotate=0: identity.
2. **Synchronise.** Two-flop synchroniser per bit, sync1 then sync2.
3. **Debounce** (DEB_LEN>0).
   - Per bit: counter of width clog2(DEB_LEN+1), plus accepted level deb.
   - On a ce tick with sync2≠deb: counter increments; when it reaches DEB_LEN, deb←sync2 and counter←0.
   - On a ce tick with sync2==deb: counter←0.
   - No ce: everything holds.
   - DEB_LEN=0: deb is a register loaded from sync2 every cycle.
4. **Edge detect.** prev←deb every cycle; rise = deb & ~prev.
5. **Arbitrate.** 4-bit one-hot-or-zero mask per channel. Priority order when several candidates qualify: up > down > left > right.
   - Mode 00: out = deb. If up&down are both set, both are cleared. If left&right are both set, both are cleared.
   - Mode 01: if rise≠0, mask ← highest-priority bit of rise. Else if (deb & mask)==0 and deb≠0, mask ← highest-priority bit of deb. Else if deb==0, mask←0. out = deb & mask.
   - Mode 10: mask changes only when (deb & mask)==0. It then takes the highest-priority bit of deb, or 0 if deb==0. Rises of other bits are ignored while the masked bit is held. out = deb & mask.
   - Mode 11: same as mode 01, restricted to {left,right}; up/down forced 0 in both candidate set and output.
6. **Output.** dir_out registered from the arbitration result. chg[c] = 1 for one cycle when the new registered value differs from the previous one.
7. **Mode or rotate change.** When mode or rotate differs from its value in the previous cycle, every mask ← 0 and that cycle's arbitration output is 0. Selection resumes the next cycle from current deb. Sync and debounce state is not cleared.

## Timing
- Reset (I_RESETn=0, asynchronous): sync, deb, prev, counters, masks, dir_out and chg all 0. Release is synchronous to clk_sys.
- Latency with DEB_LEN=0: dir_in change at edge N → sync1 N+1, sync2 N+2, deb N+3, dir_out N+4. chg pulses in the same cycle dir_out changes.
- Latency with DEB_LEN=D: after sync2 settles, deb changes on the D-th consecutive qualifying ce tick, then dir_out follows 1 cycle later.
- Edge-case behaviour:
  - A raw glitch shorter than D ce ticks never reaches deb.
  - Rise and release of different bits in the same cycle: rise wins.
  - Simultaneous rises: resolved by priority order.
  - Channels are fully independent.
- Reset asserted mid-operation: outputs drop to 0 asynchronously with no chg pulse. After release, the first output update follows normal latency.

## Test plan
- **Mode 01, DEB_LEN=0.** Hold right, then add up 10 cycles later → dir_out goes 0001 then 1000. Release up while right is still held → 0001 four cycles after the release. chg pulses on each change.
- **Mode 10.** Hold left, then add down → dir_out stays 0010. Release left → 0100. Release all → 0000.
- **Mode 00.** dir_in 1100 → 0000. dir_in 1001 → 1001.
- **Mode 11, rotate=1.** dir_in right=1 (maps to down) → 0000. dir_in up=1 (maps to right) → 0001.
- **DEB_LEN=8, ce every 4th cycle.** 20-cycle pulse on up → no output. 40-cycle pulse → dir_out 1000 after the 8th qualifying ce tick plus 1 cycle.
- **Reset.** Assert I_RESETn low while dir_out=0010 → 0000 immediately. Toggle mode 01→10 while a direction is held → one 0 cycle with chg pulses, then the held direction returns.

Source files
------------

// File: rtl/joy_dir_arbiter.sv
// Per-player joystick direction conditioner: optional rotation, 2-flop sync, debounce,
// and mode-selected arbitration (8-way cancel, 4-way last/first, 2-way horizontal).
module joy_dir_arbiter #(
    parameter int CHANNELS = 2,
    parameter int DEB_LEN  = 8
) (
    input  logic                  clk_sys,
    input  logic                  I_RESETn,
    input  logic                  ce,
    input  logic [1:0]            mode,
    input  logic                  rotate,
    input  logic [4*CHANNELS-1:0] dir_in,
    output logic [4*CHANNELS-1:0] dir_out,
    output logic [CHANNELS-1:0]   chg
);

    localparam int NB    = 4 * CHANNELS;
    localparam int CNT_W = (DEB_LEN > 0) ? $clog2(DEB_LEN + 1) : 1;

    // Bit order within a channel nibble: [3]=up [2]=down [1]=left [0]=right.
    function automatic logic [3:0] prio4(input logic [3:0] v);
        if (v[3])      prio4 = 4'b1000;
        else if (v[2]) prio4 = 4'b0100;
        else if (v[1]) prio4 = 4'b0010;
        else if (v[0]) prio4 = 4'b0001;
        else           prio4 = 4'b0000;
    endfunction

    function automatic logic [3:0] sel_last(input logic [3:0] d, input logic [3:0] r,
                                            input logic [3:0] m);
        if (r != 4'b0000)                           sel_last = prio4(r);
        else if ((d & m) == 4'b0000 && d != 4'b0000) sel_last = prio4(d);
        else if (d == 4'b0000)                      sel_last = 4'b0000;
        else                                        sel_last = m;
    endfunction

    logic [NB-1:0]       rot_in;
    logic [NB-1:0]       sync1_q, sync2_q;
    logic [NB-1:0]       deb_q;
    logic [NB-1:0]       prev_q;
    logic [NB-1:0]       rise;
    logic [NB-1:0]       mask_q, mask_d;
    logic [NB-1:0]       dir_out_q, dir_out_d;
    logic [CHANNELS-1:0] chg_q, chg_d;
    logic [1:0]          mode_q;
    logic                rot_q;
    logic                cfg_chg;

    always_comb begin
        rot_in = dir_in;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rotate)
                rot_in[4*c +: 4] = {dir_in[4*c+1], dir_in[4*c], dir_in[4*c+2], dir_in[4*c+3]};
        end
    end

    always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rot_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEB_LEN == 0) begin : g_nodeb
            always_ff @(posedge clk_sys or negedge I_RESETn) begin
                if (!I_RESETn) deb_q <= '0;
                else           deb_q <= sync2_q;
            end
        end else begin : g_deb
            localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_LEN);
            localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
            logic [CNT_W-1:0] cnt_q [NB];
            logic [CNT_W-1:0] cnt_d [NB];
            logic [NB-1:0]    deb_d;

            // A level is accepted only after DEB_LEN consecutive ce ticks disagreeing with deb.
            always_comb begin
                deb_d = deb_q;
                for (int b = 0; b < NB; b++) begin
                    cnt_d[b] = cnt_q[b];
                    if (ce) begin
                        if (sync2_q[b] != deb_q[b]) begin
                            if (cnt_q[b] + CNT_ONE == DEB_MAX) begin
                                deb_d[b] = sync2_q[b];
                                cnt_d[b] = '0;
                            end else begin
                                cnt_d[b] = cnt_q[b] + CNT_ONE;
                            end
                        end else begin
                            cnt_d[b] = '0;
                        end
                    end
                end
            end

            always_ff @(posedge clk_sys or negedge I_RESETn) begin
                if (!I_RESETn) begin
                    deb_q <= '0;
                    for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
                end else begin
                    deb_q <= deb_d;
                    for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
                end
            end
        end
    endgenerate

    assign rise    = deb_q & ~prev_q;
    assign cfg_chg = (mode != mode_q) || (rotate != rot_q);

    always_comb begin
        mask_d    = mask_q;
        dir_out_d = '0;
        chg_d     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [3:0] d, r, m, nm, o;
            d  = deb_q[4*c +: 4];
            r  = rise[4*c +: 4];
            m  = mask_q[4*c +: 4];
            nm = m;
            o  = 4'b0000;
            case (mode)
                2'b00: begin
                    nm = 4'b0000;
                    o  = d;
                    if (d[3] && d[2]) o[3:2] = 2'b00;
                    if (d[1] && d[0]) o[1:0] = 2'b00;
                end
                2'b01: begin
                    nm = sel_last(d, r, m);
                    o  = d & nm;
                end
                2'b10: begin
                    if ((d & m) == 4'b0000) nm = prio4(d);
                    o = d & nm;
                end
                default: begin
                    nm = sel_last(d & 4'b0011, r & 4'b0011, m);
                    o  = d & 4'b0011 & nm;
                end
            endcase
            // Any reconfiguration forces one idle output cycle and a fresh selection.
            if (cfg_chg) begin
                nm = 4'b0000;
                o  = 4'b0000;
            end
            mask_d[4*c +: 4]    = nm;
            dir_out_d[4*c +: 4] = o;
            chg_d[c]            = (o != dir_out_q[4*c +: 4]);
        end
    end

    always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) begin
            prev_q    <= '0;
            mask_q    <= '0;
            dir_out_q <= '0;
            chg_q     <= '0;
            mode_q    <= 2'b00;
            rot_q     <= 1'b0;
        end else begin
            prev_q    <= deb_q;
            mask_q    <= mask_d;
            dir_out_q <= dir_out_d;
            chg_q     <= chg_d;
            mode_q    <= mode;
            rot_q     <= rotate;
        end
    end

    assign dir_out = dir_out_q;
    assign chg     = chg_q;

endmodule

// File: tb/tb_joy_dir_arbiter.sv
// Directed bench for joy_dir_arbiter: one instance without debounce, one with DEB_LEN=8.
module tb_joy_dir_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce0;
    logic [1:0] mode;
    logic       rotate;
    logic [7:0] din0;
    logic [7:0] dout0;
    logic [1:0] chg0;

    logic       ce8;
    logic [1:0] mode8;
    logic       rot8;
    logic [7:0] din8;
    logic [7:0] dout8;
    logic [1:0] chg8;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    joy_dir_arbiter #(.CHANNELS(2), .DEB_LEN(0)) u_dut0 (
        .clk_sys(clk), .I_RESETn(rst_n), .ce(ce0), .mode(mode), .rotate(rotate),
        .dir_in(din0), .dir_out(dout0), .chg(chg0)
    );

    joy_dir_arbiter #(.CHANNELS(2), .DEB_LEN(8)) u_dut8 (
        .clk_sys(clk), .I_RESETn(rst_n), .ce(ce8), .mode(mode8), .rotate(rot8),
        .dir_in(din8), .dir_out(dout8), .chg(chg8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] acc;
        rst_n  = 1'b0;
        ce0    = 1'b0;
        mode   = 2'b01;
        rotate = 1'b0;
        din0   = 8'h00;
        ce8    = 1'b0;
        mode8  = 2'b01;
        rot8   = 1'b0;
        din8   = 8'h00;
        tick(3);
        check("rst_dout0", dout0, 8'h00);
        check("rst_chg0", 8'(chg0), 8'h00);
        check("rst_dout8", dout8, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // mode 01: right, then add up, then release up
        din0 = 8'h01;
        tick(3); check("m01_r_early", dout0, 8'h00);
        tick(1); check("m01_r", dout0, 8'h01);
        check("m01_r_chg", 8'(chg0), 8'h01);
        tick(1); check("m01_r_chg_end", 8'(chg0), 8'h00);
        tick(5);
        din0 = 8'h09;
        tick(3); check("m01_up_early", dout0, 8'h01);
        tick(1); check("m01_up", dout0, 8'h08);
        check("m01_up_chg", 8'(chg0), 8'h01);
        din0 = 8'h01;
        tick(3); check("m01_rel_early", dout0, 8'h08);
        tick(1); check("m01_rel", dout0, 8'h01);
        check("m01_rel_chg", 8'(chg0), 8'h01);

        // channel independence
        din0 = 8'h21;
        tick(4); check("ch1_left", dout0, 8'h21);
        check("ch1_chg", 8'(chg0), 8'h02);
        din0 = 8'h01;
        tick(4); check("ch1_rel", dout0, 8'h01);

        // mode toggle 01 -> 10 with right held
        mode = 2'b10;
        tick(1); check("tog_zero", dout0, 8'h00);
        check("tog_zero_chg", 8'(chg0), 8'h01);
        tick(1); check("tog_back", dout0, 8'h01);
        check("tog_back_chg", 8'(chg0), 8'h01);

        // mode 10: first-held
        din0 = 8'h00;
        tick(4); check("m10_idle", dout0, 8'h00);
        din0 = 8'h02;
        tick(4); check("m10_left", dout0, 8'h02);
        din0 = 8'h06;
        tick(6); check("m10_add_down", dout0, 8'h02);
        din0 = 8'h04;
        tick(3); check("m10_rel_early", dout0, 8'h02);
        tick(1); check("m10_rel_left", dout0, 8'h04);
        din0 = 8'h00;
        tick(4); check("m10_rel_all", dout0, 8'h00);

        // mode 00: opposite cancel
        mode = 2'b00;
        tick(2);
        din0 = 8'h0C;
        tick(4); check("m00_ud", dout0, 8'h00);
        din0 = 8'h09;
        tick(4); check("m00_diag", dout0, 8'h09);
        din0 = 8'h0F;
        tick(4); check("m00_all", dout0, 8'h00);
        din0 = 8'h06;
        tick(4); check("m00_dl", dout0, 8'h06);
        din0 = 8'h00;
        tick(4);

        // mode 11 with rotation
        mode   = 2'b11;
        rotate = 1'b1;
        tick(2);
        din0 = 8'h01;
        tick(4); check("m11_rot_down", dout0, 8'h00);
        tick(2); check("m11_rot_down2", dout0, 8'h00);
        din0 = 8'h08;
        tick(4); check("m11_rot_right", dout0, 8'h01);
        din0 = 8'h00;
        tick(4);

        // mode 11 unrotated: simultaneous left+right rise, left has priority
        rotate = 1'b0;
        tick(2);
        din0 = 8'h0B;
        tick(4); check("m11_lr", dout0, 8'h02);
        din0 = 8'h00;
        tick(4);

        // asynchronous reset mid-operation
        mode = 2'b01;
        tick(2);
        din0 = 8'h02;
        tick(4); check("pre_rst", dout0, 8'h02);
        rst_n = 1'b0;
        #1;
        check("async_rst", dout0, 8'h00);
        check("async_rst_chg", 8'(chg0), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3); check("post_rst_early", dout0, 8'h00);
        tick(1); check("post_rst", dout0, 8'h02);

        // debounce: 20-cycle glitch never accepted
        acc = 8'h00;
        for (int t = 0; t < 60; t++) begin
            din8 = (t < 20) ? 8'h08 : 8'h00;
            ce8  = (t % 4 == 0);
            tick(1);
            acc = acc | dout8;
        end
        check("deb_glitch", acc, 8'h00);

        // debounce: 40-cycle pulse accepted on 8th qualifying ce (edge 33), output edge 34
        for (int t = 0; t < 80; t++) begin
            din8 = (t < 40) ? 8'h08 : 8'h00;
            ce8  = (t % 4 == 0);
            tick(1);
            if (t + 1 == 33) check("deb_on_early", dout8, 8'h00);
            if (t + 1 == 34) begin
                check("deb_on", dout8, 8'h08);
                check("deb_on_chg", 8'(chg8), 8'h01);
            end
            if (t + 1 == 73) check("deb_off_early", dout8, 8'h08);
            if (t + 1 == 74) check("deb_off", dout8, 8'h00);
        end
        ce8 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
